// File: rtl/fun_fpualt_wb.sv
// fun_fpualt_wb: receive side of the sqrt/div alternate-writeback interface.
// A tag arrives with alt_wen and its data DATA_LAG cycles later. The block
// pairs the two, buffers completed results and inserts them into the FP
// writeback port in cycles the regular FU leaves free.
// Optional build macro FPU_ALTWB_BYPASS_EN: a result that arrives while the
// FIFO is empty, the output register is idle and the port is free goes
// straight to wb_* in its arrival cycle.
module fun_fpualt_wb #(
    parameter logic H        = 1'b0,
    parameter int   DATA_LAG = 5,
    parameter int   DEPTH    = 4,
    localparam int  S        = H ? 16 : 0,
    localparam int  DW       = S + 68
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          except,
    input  logic [3:0]    alt_en,
    input  logic [9:0]    alt_II,
    input  logic [12:0]   alt_op,
    input  logic [8:0]    alt_reg,
    input  logic          alt_wen,
    input  logic [DW-1:0] alt_data,
    input  logic          fu_wb_busy,
    output logic          wb_en,
    output logic [9:0]    wb_II,
    output logic [12:0]   wb_op,
    output logic [8:0]    wb_reg,
    output logic [DW-1:0] wb_data,
    output logic [2:0]    alt_pause,
    output logic          alt_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + DATA_LAG + 1) + 1;

    typedef struct packed {
        logic [9:0]  ii;
        logic [12:0] op;
        logic [8:0]  rg;
    } tag_t;

    typedef struct packed {
        tag_t          tag;
        logic [DW-1:0] data;
    } ent_t;

    logic [DATA_LAG:1] vldPipe;
    tag_t              tagPipe [DATA_LAG:1];
    ent_t              mem [DEPTH];
    logic [AW-1:0]     wrPtr, rdPtr;
    logic [AW:0]       count;
    logic              wbEnQ;
    ent_t              wbQ;
    logic              ovfQ;

    logic          arrVld, fifoEmpty, fifoFull, bypass;
    logic          canPop, popFifo, passThru, pushReq, pushOk;
    ent_t          arrEntry, wbOut;
    logic [PW-1:0] pend;
    logic          unusedEn;

    // only bits 0 and 3 of the enable vector qualify a tag
    assign unusedEn = ^alt_en[2:1];

    // Arrival, drain and push decisions for this cycle
    always_comb begin
        arrVld    = vldPipe[DATA_LAG];
        arrEntry  = '{tag: tagPipe[DATA_LAG], data: alt_data};
        fifoEmpty = (count == '0);
        fifoFull  = (count == (AW+1)'(DEPTH));
`ifdef FPU_ALTWB_BYPASS_EN
        // skip the output register only when it has nothing of its own to show
        bypass    = arrVld & fifoEmpty & ~fu_wb_busy & ~wbEnQ & ~except;
`else
        bypass    = 1'b0;
`endif
        // an arriving result counts as available even before it lands in the FIFO
        canPop    = ~fu_wb_busy & ~bypass & (~fifoEmpty | arrVld);
        popFifo   = canPop & ~fifoEmpty;
        passThru  = canPop & fifoEmpty;
        pushReq   = arrVld & ~bypass & ~passThru;
        pushOk    = pushReq & (~fifoFull | popFifo);
    end

    // Credit: everything already queued plus every tag whose data is still coming
    always_comb begin
        pend = PW'(count);
        for (int i = 1; i <= DATA_LAG; i++) pend = pend + PW'(vldPipe[i]);
    end

    assign alt_pause = {3{pend >= PW'(DEPTH - 1)}};

    // Tag-valid pipe; a flush also kills a tag presented in the same cycle
    always_ff @(posedge clk) begin
        if (rst || except) begin
            vldPipe <= '0;
        end else begin
            vldPipe[1] <= alt_wen & alt_en[0] & alt_en[3];
            for (int i = 2; i <= DATA_LAG; i++) vldPipe[i] <= vldPipe[i-1];
        end
    end

    // Tag payload pipe; meaningless without its valid bit, so never reset
    always_ff @(posedge clk) begin
        tagPipe[1] <= '{ii: alt_II, op: alt_op, rg: alt_reg};
        for (int i = 2; i <= DATA_LAG; i++) tagPipe[i] <= tagPipe[i-1];
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (pushOk && !rst && !except) mem[wrPtr] <= arrEntry;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst || except) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk)  wrPtr <= wrPtr + 1'b1;
            if (popFifo) rdPtr <= rdPtr + 1'b1;
            if (pushOk && !popFifo)      count <= count + 1'b1;
            else if (!pushOk && popFifo) count <= count - 1'b1;
        end
    end

    // Registered writeback: FIFO head, else the result arriving now, else zeros
    always_ff @(posedge clk) begin
        if (rst || except) begin
            wbEnQ <= 1'b0;
            wbQ   <= '0;
        end else if (popFifo) begin
            wbEnQ <= 1'b1;
            wbQ   <= mem[rdPtr];
        end else if (passThru) begin
            wbEnQ <= 1'b1;
            wbQ   <= arrEntry;
        end else begin
            wbEnQ <= 1'b0;
            wbQ   <= '0;
        end
    end

    // Sticky overflow: a result had nowhere to go
    always_ff @(posedge clk) begin
        if (rst)                                          ovfQ <= 1'b0;
        else if (pushReq && fifoFull && !popFifo && !except) ovfQ <= 1'b1;
    end

    assign wbOut   = bypass ? arrEntry : wbQ;
    assign wb_en   = wbEnQ | bypass;
    assign wb_II   = wbOut.tag.ii;
    assign wb_op   = wbOut.tag.op;
    assign wb_reg  = wbOut.tag.rg;
    assign wb_data = wbOut.data;
    assign alt_ovf = ovfQ;

endmodule
